// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the configuration scan-chain loader.
package cfg_chain_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        DONE
    } state_e;

    // Number of bits actually shifted out of the last word of a load.
    function automatic int unsigned final_word_bits(input int unsigned chain_len);
        int unsigned rem;
        rem = chain_len % WORD_W;
        return (rem == 0) ? WORD_W : rem;
    endfunction

endpackage

// File: rtl/cfg_bit_deser.sv
// Readback deserialiser: packs chain output bits MSB-first into 32-bit words,
// flushing a left-aligned, zero-padded partial word on request.
module cfg_bit_deser
    import cfg_chain_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sample,
    input  logic              sdi,
    input  logic              flush,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              valid_q, valid_d;

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (sample) begin
            sh_d  = {sh_q[WORD_W-2:0], sdi};
            cnt_d = cnt_q + 6'd1;
            if (cnt_d == 6'(WORD_W) || flush) begin
                valid_d = 1'b1;
                data_d  = sh_d << (6'(WORD_W) - cnt_d);
                cnt_d   = '0;
                sh_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign rb_data  = data_q;
    assign rb_valid = valid_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration bitstream loader: serialises 32-bit words MSB-first onto the
// fabric scan chain. Define CFG_READBACK_EN to capture the old chain contents.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 4096
) (
    input  logic              prog_clk,
    input  logic              prog_rst,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              prog_sdo,
    output logic              prog_en,
    input  logic              chain_sdi,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);

    localparam int unsigned   CW         = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX   = CW'(CHAIN_LEN - 1);
    localparam logic [5:0]    FINAL_BITS = 6'(final_word_bits(CHAIN_LEN));

    state_e            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [5:0]        word_left_q, word_left_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              prog_en_q, prog_en_d;
    logic              prog_sdo_q, prog_sdo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              handshake;
    logic              last_bit;
    logic              word_end;
    logic [CW-1:0]     bit_cnt_inc;
    logic [CW-1:0]     ld_cnt;
    logic [31:0]       remaining;
    logic [5:0]        next_word_len;

    always_comb begin
        handshake   = cfg_valid & cfg_ready_q;
        last_bit    = (bit_cnt_q == LAST_IDX);
        word_end    = (word_left_q == 6'd1);
        bit_cnt_inc = bit_cnt_q + CW'(1);
        // A word loaded at a boundary starts at the post-increment count.
        ld_cnt        = (state_q == SHIFT) ? bit_cnt_inc : bit_cnt_q;
        remaining     = CHAIN_LEN - 32'(ld_cnt);
        next_word_len = (remaining < WORD_W) ? FINAL_BITS : 6'(WORD_W);

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_left_d = word_left_q;
        shreg_d     = shreg_q;
        done_d      = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    bit_cnt_d = '0;
                    done_d    = 1'b0;
                end
            end
            FETCH: begin
                if (handshake) begin
                    shreg_d     = cfg_data;
                    word_left_d = next_word_len;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d     = {shreg_q[WORD_W-2:0], 1'b0};
                bit_cnt_d   = bit_cnt_inc;
                word_left_d = word_left_q - 6'd1;
                if (last_bit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (word_end) begin
                    if (handshake) begin
                        shreg_d     = cfg_data;
                        word_left_d = next_word_len;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d      = (state_d == FETCH) || (state_d == SHIFT);
        prog_en_d   = (state_d == SHIFT);
        prog_sdo_d  = (state_d == SHIFT) ? shreg_d[WORD_W-1] : 1'b0;
        cfg_ready_d = (state_d == FETCH) ||
                      ((state_d == SHIFT) && (word_left_d == 6'd1) && (bit_cnt_d != LAST_IDX));
    end

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            word_left_q <= '0;
            shreg_q     <= '0;
            cfg_ready_q <= 1'b0;
            prog_en_q   <= 1'b0;
            prog_sdo_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_left_q <= word_left_d;
            shreg_q     <= shreg_d;
            cfg_ready_q <= cfg_ready_d;
            prog_en_q   <= prog_en_d;
            prog_sdo_q  <= prog_sdo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign prog_en   = prog_en_q;
    assign prog_sdo  = prog_sdo_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CFG_READBACK_EN
    logic rb_flush;
    assign rb_flush = prog_en_q & last_bit;

    cfg_bit_deser u_deser (
        .clk      (prog_clk),
        .rst      (prog_rst),
        .sample   (prog_en_q),
        .sdi      (chain_sdi),
        .flush    (rb_flush),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );
`else
    logic unused_chain_sdi;
    assign unused_chain_sdi = chain_sdi;
    assign rb_data  = '0;
    assign rb_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: 64-bit and 40-bit chains with behavioural chain models.
module tb_cfg_chain_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start64, start40;
    logic [31:0] cfg_data;
    logic        cfg_valid;

    logic        ready64, sdo64, en64, busy64, done64, sdi64, rbv64;
    logic        ready40, sdo40, en40, busy40, done40, sdi40, rbv40;
    logic [31:0] rbd64, rbd40;

    logic        sel40;
    logic        en, sdo, ready, busy, done;

    logic [63:0] chain64;
    logic [39:0] chain40;
    logic        preload;
    logic [63:0] preload_val;

    int          checks = 0;
    int          failures = 0;
    int          rb_n = 0;
    int          rb_active = 0;
    logic [31:0] rb_seen [4];

    typedef struct {
        bit          use40;
        logic [31:0] w0;
        logic [31:0] w1;
        int          stall;
        bit          midstart;
        int          exp_bits;
        logic [63:0] exp_stream;
        int          exp_run;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    cfg_chain_loader #(.CHAIN_LEN(64)) u_dut64 (
        .prog_clk (clk),     .prog_rst (rst),       .start    (start64),
        .cfg_data (cfg_data), .cfg_valid (cfg_valid), .cfg_ready (ready64),
        .prog_sdo (sdo64),   .prog_en  (en64),      .chain_sdi (sdi64),
        .busy     (busy64),  .done     (done64),    .rb_data  (rbd64),
        .rb_valid (rbv64)
    );

    cfg_chain_loader #(.CHAIN_LEN(40)) u_dut40 (
        .prog_clk (clk),     .prog_rst (rst),       .start    (start40),
        .cfg_data (cfg_data), .cfg_valid (cfg_valid), .cfg_ready (ready40),
        .prog_sdo (sdo40),   .prog_en  (en40),      .chain_sdi (sdi40),
        .busy     (busy40),  .done     (done40),    .rb_data  (rbd40),
        .rb_valid (rbv40)
    );

    always_comb begin
        en    = sel40 ? en40    : en64;
        sdo   = sel40 ? sdo40   : sdo64;
        ready = sel40 ? ready40 : ready64;
        busy  = sel40 ? busy40  : busy64;
        done  = sel40 ? done40  : done64;
    end

    // Behavioural scan chains: shift in prog_sdo while prog_en, far end feeds chain_sdi.
    always @(posedge clk) begin
        if (preload) chain64 <= preload_val;
        else if (en64) chain64 <= {chain64[62:0], sdo64};
        if (preload) chain40 <= '0;
        else if (en40) chain40 <= {chain40[38:0], sdo40};
    end
    assign sdi64 = chain64[63];
    assign sdi40 = chain40[39];

    always @(negedge clk) begin
        if (rbv64) begin
            if (rb_n < 4) rb_seen[rb_n] = rbd64;
            rb_n = rb_n + 1;
        end
        if (rbv64 || rbv40 || rbd64 != 32'd0 || rbd40 != 32'd0) rb_active = rb_active + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_load(input int idx);
        vec_t        v;
        logic [31:0] words [2];
        logic [63:0] stream;
        logic [63:0] chain_now;
        int widx, stall_left, en_cnt, run, best_run, gap;
        int hs_cyc, first_en, last_en, done_cyc, busy_err;
        bit seen, finished;
        v = vecs[idx];
        words[0] = v.w0;
        words[1] = v.w1;
        stream = '0;
        widx = 0; stall_left = v.stall; en_cnt = 0; run = 0; best_run = 0; gap = 0;
        hs_cyc = -10; first_en = -100; last_en = -100; done_cyc = -1; busy_err = 0;
        seen = 0; finished = 0;

        sel40 = v.use40;
        @(negedge clk);
        start64 = !v.use40;
        start40 = v.use40;
        @(negedge clk);
        start64 = 1'b0;
        start40 = 1'b0;
        check($sformatf("v%0d_done_clr", idx), 64'(done), 64'd0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (en) begin
                en_cnt = en_cnt + 1;
                stream = {stream[62:0], sdo};
                if (!seen) first_en = cyc;
                seen = 1;
                last_en = cyc;
                run = run + 1;
                if (run > best_run) best_run = run;
                if (!busy) busy_err = busy_err + 1;
            end else begin
                run = 0;
                if (seen && busy) gap = gap + 1;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1;
                break;
            end
            start64 = v.midstart && !v.use40 && en && en_cnt == 10;
            start40 = v.midstart &&  v.use40 && en && en_cnt == 10;
            if (widx == 1 && stall_left > 0 && ready && !en) stall_left = stall_left - 1;
            cfg_valid = (widx < 2) && !(widx == 1 && stall_left > 0);
            cfg_data  = (widx < 2) ? words[widx] : 32'h0;
            if (cfg_valid && ready) begin
                if (widx == 0) hs_cyc = cyc;
                widx = widx + 1;
            end
            @(negedge clk);
        end
        start64 = 1'b0;
        start40 = 1'b0;
        cfg_valid = 1'b0;

        check($sformatf("v%0d_finished", idx), 64'(finished), 64'd1);
        check($sformatf("v%0d_bits", idx), 64'(en_cnt), 64'(v.exp_bits));
        check($sformatf("v%0d_stream", idx), stream, v.exp_stream);
        check($sformatf("v%0d_run", idx), 64'(best_run), 64'(v.exp_run));
        check($sformatf("v%0d_gap", idx), 64'(gap), 64'(v.stall));
        check($sformatf("v%0d_latency", idx), 64'(first_en - hs_cyc), 64'd1);
        check($sformatf("v%0d_done_at", idx), 64'(done_cyc), 64'(last_en + 1));
        check($sformatf("v%0d_busy", idx), 64'(busy_err), 64'd0);
        check($sformatf("v%0d_busy_done", idx), 64'(busy), 64'd0);
        chain_now = v.use40 ? {24'd0, chain40} : chain64;
        check($sformatf("v%0d_chain", idx), chain_now, v.exp_stream);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done_held", idx), 64'({done, en, busy}), 64'b100);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'hA5A5_0001, 32'h8000_00FF, 0, 1'b0, 64, 64'hA5A5_0001_8000_00FF, 64};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hC000_0000, 0, 1'b0, 40, 64'h0000_00FF_FFFF_FFC0, 40};
        vecs[2] = '{1'b0, 32'hA5A5_0001, 32'h8000_00FF, 5, 1'b0, 64, 64'hA5A5_0001_8000_00FF, 32};
        vecs[3] = '{1'b0, 32'hA5A5_0001, 32'h8000_00FF, 0, 1'b1, 64, 64'hA5A5_0001_8000_00FF, 64};
        vecs[4] = '{1'b1, 32'h1234_5678, 32'h9F00_0000, 3, 1'b1, 40, 64'h0000_0012_3456_789F, 32};

        rst = 1'b1;
        start64 = 1'b0;
        start40 = 1'b0;
        cfg_data = '0;
        cfg_valid = 1'b0;
        sel40 = 1'b0;
        preload = 1'b1;
        preload_val = '0;
        repeat (3) @(negedge clk);
        check("reset64", 64'({ready64, sdo64, en64, busy64, done64, rbv64, rbd64}), 64'd0);
        check("reset40", 64'({ready40, sdo40, en40, busy40, done40, rbv40, rbd40}), 64'd0);
        rst = 1'b0;
        preload = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_load(i);

        // Reset in the middle of a load, after 17 bits have gone out.
        begin
            int  cnt, widx;
            bit  reached;
            logic [31:0] words [2];
            words[0] = 32'hA5A5_0001;
            words[1] = 32'h8000_00FF;
            cnt = 0; widx = 0; reached = 0;
            sel40 = 1'b0;
            start64 = 1'b1;
            @(negedge clk);
            start64 = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (en) cnt = cnt + 1;
                if (cnt == 17) begin
                    reached = 1;
                    break;
                end
                cfg_valid = (widx < 2);
                cfg_data  = (widx < 2) ? words[widx] : 32'h0;
                if (cfg_valid && ready) widx = widx + 1;
                @(negedge clk);
            end
            check("rst_reach17", 64'(reached), 64'd1);
            check("rst_pre_busy", 64'({busy64, en64}), 64'b11);
            rst = 1'b1;
            cfg_valid = 1'b0;
            #1;
            check("rst_async", 64'({ready64, sdo64, en64, busy64, done64}), 64'd0);
            @(negedge clk);
            check("rst_hold", 64'({ready64, sdo64, en64, busy64, done64}), 64'd0);
            rst = 1'b0;
            @(negedge clk);
            check("rst_idle", 64'({ready64, en64, busy64}), 64'd0);
        end
        run_load(0);

        // Readback: chain preloaded with known contents, then reloaded.
        @(negedge clk);
        preload_val = 64'h1234_5678_9ABC_DEF0;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        rb_n = 0;
        run_load(0);
`ifdef CFG_READBACK_EN
        check("rb_count", 64'(rb_n), 64'd2);
        check("rb_word0", 64'(rb_seen[0]), 64'h1234_5678);
        check("rb_word1", 64'(rb_seen[1]), 64'h9ABC_DEF0);
`else
        check("rb_quiet", 64'(rb_active), 64'd0);
        check("rb_count", 64'(rb_n), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
